// File: rtl/expr_lane_pipe.sv
// expr_lane_pipe: LANES independent W-bit lanes evaluating one selectable
// arithmetic/logic/shift/compare/divide op, registered through a PIPE-deep valid/ready pipeline.
module expr_lane_pipe #(
  parameter int W     = 6,
  parameter int LANES = 4,
  parameter int PIPE  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic               sgn,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] y,
  output logic [LANES-1:0]   red,
  output logic [LANES-1:0]   dz
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_XNOR = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_GE   = 3'd6,
    OP_DIV  = 3'd7
  } op_e;

  typedef struct packed {
    logic [W-1:0] y;
    logic         dz;
  } lane_res_t;

  typedef struct packed {
    logic [LANES*W-1:0] y;
    logic [LANES-1:0]   red;
    logic [LANES-1:0]   dz;
  } stage_t;

  function automatic lane_res_t eval_lane(input op_e          lop,
                                          input logic         lsgn,
                                          input logic [W-1:0] la,
                                          input logic [W-1:0] lb);
    lane_res_t    r;
    logic [W-1:0] mag_a;
    logic [W-1:0] mag_b;
    logic [W-1:0] quo;
    logic         big_shift;
    r         = '0;
    quo       = '0;
    big_shift = 33'(lb) >= 33'(W);
    // Divide on magnitudes so -2^(W-1)/-1 wraps back to -2^(W-1) without overflow.
    mag_a     = (lsgn && la[W-1]) ? -la : la;
    mag_b     = (lsgn && lb[W-1]) ? -lb : lb;
    case (lop)
      OP_ADD:  r.y = la + lb;
      OP_SUB:  r.y = la - lb;
      OP_AND:  r.y = la & lb;
      OP_XNOR: r.y = ~(la ^ lb);
      OP_SHL:  r.y = big_shift ? '0 : (la << lb);
      OP_SHR: begin
        if (big_shift)  r.y = {W{lsgn & la[W-1]}};
        else if (lsgn)  r.y = $signed(la) >>> lb;
        else            r.y = la >> lb;
      end
      OP_GE:   r.y[0] = lsgn ? ($signed(la) >= $signed(lb)) : (la >= lb);
      OP_DIV: begin
        if (lb == '0) begin
          r.y  = '1;
          r.dz = 1'b1;
        end else begin
          quo = mag_a / mag_b;
          r.y = (lsgn && (la[W-1] ^ lb[W-1])) ? -quo : quo;
        end
      end
    endcase
    return r;
  endfunction

  stage_t          eval_res;
  lane_res_t       lane_r;
  logic            adv_chain;
  logic [PIPE-1:0] stage_adv;
  logic [PIPE-1:0] valid_q;
  logic [PIPE-1:0] valid_d;
  stage_t          data_q [PIPE];
  stage_t          data_d [PIPE];

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    eval_res = '0;
    lane_r   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_r                = eval_lane(op_e'(op), sgn, a[i*W +: W], b[i*W +: W]);
      eval_res.y[i*W +: W]  = lane_r.y;
      eval_res.red[i]       = ^lane_r.y;
      eval_res.dz[i]        = lane_r.dz;
    end
  end

  // A stage may move when it is empty or everything downstream of it moves.
  always_comb begin
    stage_adv         = '0;
    adv_chain         = out_ready | ~valid_q[PIPE-1];
    stage_adv[PIPE-1] = adv_chain;
    for (int k = PIPE - 2; k >= 0; k--) begin
      adv_chain    = adv_chain | ~valid_q[k];
      stage_adv[k] = adv_chain;
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < PIPE; k++) data_d[k] = data_q[k];
    if (stage_adv[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) data_d[0] = eval_res;
    end
    for (int k = 1; k < PIPE; k++) begin
      if (stage_adv[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments; data stages are reset too
  // because the output stage must read as zero while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < PIPE; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < PIPE; k++) data_q[k] <= data_d[k];
    end
  end

  assign in_ready  = stage_adv[0];
  assign out_valid = valid_q[PIPE-1];
  assign y         = data_q[PIPE-1].y;
  assign red       = data_q[PIPE-1].red;
  assign dz        = data_q[PIPE-1].dz;

endmodule

// File: doc/expr_lane_pipe.md
Name: expr_lane_pipe

Overview:
- Parametrised, pipelined successor to the flat mixed-signedness expression blocks used in regression.
- Evaluates one selectable arithmetic, logic, shift, compare or divide operation on LANES independent W-bit operand pairs.
- Signedness is chosen at runtime. Results are registered through a PIPE-stage valid/ready pipeline with full backpressure.
- Sits between a stimulus source and a checker: one operation per handshake, packed lane results plus per-lane status out.

Parameters:
- W, 6, lane operand/result width in bits (legal 2..32).
- LANES, 4, number of independent lanes.
- PIPE, 2, pipeline depth = latency in cycles from input accept to out_valid (legal 1..4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- op  input  3  operation select (see Behaviour).
- sgn  input  1  1 = operands are two's-complement signed; 0 = unsigned.
- a  input  LANES*W  packed operand A; lane i = a[i*W +: W].
- b  input  LANES*W  packed operand B, same packing.
- out_valid  output  1  y/red/dz hold a valid result.
- out_ready  input  1  consumer takes result this cycle.
- y  output  LANES*W  packed lane results.
- red  output  LANES  per-lane XOR reduction of the lane result.
- dz  output  LANES  per-lane divide-by-zero flag (op 7 only).

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-high.
- Reset values: all stage valid bits 0, out_valid=0, y=0, red=0, dz=0. in_ready=1 after reset deasserts.
- Reset mid-operation discards all in-flight results; no output is produced for them.
- Handshake:
  - Accept occurs when in_valid&&in_ready. Output transfer occurs when out_valid&&out_ready.
  - Stage k advances when stage k+1 is empty or advancing. The last stage advances on out_ready or when empty.
  - in_ready = stage0 empty or stage0 advancing (combinational from out_ready; no bubble when the pipe is full and draining).
  - With out_ready held 1, throughput is one op per cycle and latency is exactly PIPE cycles.
  - While out_valid=1 and out_ready=0, y/red/dz are held stable.
  - Inputs are sampled only on accept. op/sgn travel with the data, so mixed ops in flight are legal.
- Operations (each lane independent; result truncated to W bits):
  - 0 add: a+b modulo 2^W.
  - 1 sub: a-b modulo 2^W.
  - 2 and: a&b.
  - 3 xnor: ~(a^b).
  - 4 shl: a << s.
  - 5 shr: a >> s; arithmetic (sign fill) when sgn=1, logical when sgn=0.
  - 6 ge: (a>=b), compared signed when sgn=1 and unsigned otherwise; result zero-extended to W.
  - 7 div: a/b; quotient truncated toward zero when signed.
- Shift amount s: b lane treated as unsigned.
  - s>=W with shl gives 0.
  - s>=W with shr gives all sign bits when sgn=1, otherwise 0.
- Divide boundaries:
  - b==0 gives y lane all ones and dz lane 1.
  - Signed -2^(W-1)/-1 gives -2^(W-1) (wrap), dz=0.
  - dz=0 for every op other than 7.
- Pipeline staging: full evaluation happens in stage 0. Later stages are register-only, so PIPE changes latency but not results.
- red[i] = ^y lane i, registered with y.

Test Plan:
- Reset mid-flight (W=6, LANES=4, PIPE=2): accept 2 ops, assert reset 1 cycle -> out_valid=0, y=0, red=0, dz=0; first new op appears exactly 2 cycles after accept.
- Add/sub wrap: lane0 a=0x3F, b=0x01, op0 -> y lane0=0x00, red[0]=0. Lane1 a=0x00, b=0x01, op1 -> 0x3F, red[1]=0.
- Signedness: a=0x3F, b=0x01, op6 -> y=0x00 with sgn=1, y=0x01 with sgn=0. Op5 with a=0x30, b=2 -> 0x3C when sgn=1, 0x0C when sgn=0. b=7 with sgn=1 -> 0x3F.
- Divide: sgn=1, a=0x39 (-7), b=2 -> 0x3D (-3), dz=0. a=0x20, b=0x3F -> 0x20. b=0 -> 0x3F with dz=1; other lanes unaffected.
- Backpressure: out_ready=0 and stream ops until in_ready=0, which happens after PIPE+... accepts, at most PIPE outstanding. Hold 5 cycles -> y stable. Raise out_ready -> results drain in order, one per cycle, no loss or duplication.
- Back-to-back throughput: 16 random mixed ops with out_ready=1 -> 16 outputs on consecutive cycles after a PIPE-cycle gap. Repeat with PIPE=1 and PIPE=4, matching a reference model.
